// File: rtl/pmod_spi_solo_reg_sequencer.sv
// Register command sequencer for the single-peripheral SPI driver.
// Loads TX bytes, launches one transfer, drains RX bytes back.
module pmod_spi_solo_reg_sequencer #(
  parameter int parm_tx_len_bits = 11,
  parameter int parm_wait_cyc_bits = 2,
  parameter int parm_rx_len_bits = 11,
  parameter logic [7:0] parm_wr_cmd = 8'h0A,
  parameter logic [7:0] parm_rd_cmd = 8'h0B,
  parameter logic [parm_wait_cyc_bits-1:0] parm_wait_cyc = '0,
  parameter logic [15:0] parm_timeout = 16'd50000
) (
  input  logic i_clk_20mhz,
  input  logic i_rst_20mhz,
  input  logic i_cmd_valid,
  output logic o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [7:0] i_cmd_addr,
  input  logic [7:0] i_cmd_wdata,
  input  logic [3:0] i_cmd_rlen,
  output logic [7:0] o_rd_data,
  output logic o_rd_valid,
  output logic o_done,
  output logic o_err,
  output logic o_busy,
  output logic o_go_stand,
  input  logic i_spi_idle,
  output logic [parm_tx_len_bits-1:0] o_tx_len,
  output logic [parm_wait_cyc_bits-1:0] o_wait_cyc,
  output logic [parm_rx_len_bits-1:0] o_rx_len,
  output logic [7:0] o_tx_data,
  output logic o_tx_enqueue,
  input  logic i_tx_ready,
  input  logic [7:0] i_rx_data,
  output logic o_rx_dequeue,
  input  logic i_rx_valid,
  input  logic i_rx_avail
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GO,
    S_XFER,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [parm_tx_len_bits-1:0] tx_len_q, tx_len_d;
  logic [parm_rx_len_bits-1:0] rx_len_q, rx_len_d;
  logic [parm_rx_len_bits-1:0] rcv_q, rcv_d;
  logic [1:0] idx_q, idx_d;
  logic [15:0] tmo_q, tmo_d;
  logic pend_q, pend_d;
  logic err_q, err_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d;

  logic [7:0] tx_byte;
  logic [3:0] rlen_eff;
  logic tx_last;
  logic tmo_hit;

  assign rlen_eff = (i_cmd_rlen == 4'd0) ? 4'd1 : i_cmd_rlen;
  assign tx_last = (op_q == 2'b00) ? (idx_q == 2'd2) : (idx_q == 2'd1);
  assign tmo_hit = (tmo_q == parm_timeout);

  always_comb begin
    tx_byte = wdata_q;
    unique case (idx_q)
      2'd0: tx_byte = (op_q == 2'b00) ? parm_wr_cmd : parm_rd_cmd;
      2'd1: tx_byte = addr_q;
      default: tx_byte = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    tx_len_d = tx_len_q;
    rx_len_d = rx_len_q;
    rcv_d = rcv_q;
    idx_d = idx_q;
    tmo_d = tmo_q;
    pend_d = pend_q;
    err_d = err_q;
    rd_data_d = rd_data_q;
    rd_valid_d = 1'b0;
    o_tx_enqueue = 1'b0;
    o_go_stand = 1'b0;
    o_rx_dequeue = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          op_d = i_cmd_op;
          addr_d = i_cmd_addr;
          wdata_d = i_cmd_wdata;
          idx_d = 2'd0;
          rcv_d = '0;
          pend_d = 1'b0;
          err_d = 1'b0;
          tx_len_d = '0;
          rx_len_d = '0;
          state_d = S_LOAD;
          unique case (i_cmd_op)
            2'b00: tx_len_d = parm_tx_len_bits'(3);
            2'b01: begin
              tx_len_d = parm_tx_len_bits'(2);
              rx_len_d = parm_rx_len_bits'(1);
            end
            2'b10: begin
              tx_len_d = parm_tx_len_bits'(2);
              rx_len_d = parm_rx_len_bits'(rlen_eff);
            end
            default: begin
              err_d = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_LOAD: begin
        if (i_tx_ready) begin
          o_tx_enqueue = 1'b1;
          idx_d = idx_q + 2'd1;
          if (tx_last) begin
            tmo_d = '0;
            state_d = S_GO;
          end
        end
      end
      S_GO: begin
        tmo_d = tmo_q + 16'd1;
        if (tmo_hit) begin
          err_d = 1'b1;
          state_d = S_DONE;
        end else if (!i_spi_idle) begin
          state_d = S_XFER;
        end else begin
          o_go_stand = 1'b1;
        end
      end
      S_XFER: begin
        tmo_d = tmo_q + 16'd1;
        if (tmo_hit) begin
          err_d = 1'b1;
          state_d = S_DONE;
        end else if (i_spi_idle) begin
          state_d = (rx_len_q != '0) ? S_DRAIN : S_DONE;
        end
      end
      S_DRAIN: begin
        tmo_d = tmo_q + 16'd1;
        if (tmo_hit) begin
          err_d = 1'b1;
          state_d = S_DONE;
        end else if (rcv_q == rx_len_q) begin
          state_d = S_DONE;
        end else if (pend_q) begin
          // a single pop is in flight; wait for its data strobe
          if (i_rx_valid) begin
            pend_d = 1'b0;
            rd_data_d = i_rx_data;
            rd_valid_d = 1'b1;
            rcv_d = rcv_q + parm_rx_len_bits'(1);
          end
        end else if (i_rx_avail) begin
          o_rx_dequeue = 1'b1;
          pend_d = 1'b1;
        end
      end
      S_DONE: begin
        pend_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state_q <= S_IDLE;
      op_q <= 2'b00;
      addr_q <= '0;
      wdata_q <= '0;
      tx_len_q <= '0;
      rx_len_q <= '0;
      rcv_q <= '0;
      idx_q <= 2'd0;
      tmo_q <= '0;
      pend_q <= 1'b0;
      err_q <= 1'b0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      tx_len_q <= tx_len_d;
      rx_len_q <= rx_len_d;
      rcv_q <= rcv_d;
      idx_q <= idx_d;
      tmo_q <= tmo_d;
      pend_q <= pend_d;
      err_q <= err_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_busy = (state_q != S_IDLE);
  assign o_done = (state_q == S_DONE);
  assign o_err = (state_q == S_DONE) && err_q;
  assign o_rd_data = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_tx_data = tx_byte;
  assign o_tx_len = tx_len_q;
  assign o_rx_len = rx_len_q;
  assign o_wait_cyc = parm_wait_cyc;

endmodule
